// File: rtl/uart_defs.sv
`default_nettype none
// ============================================================================
//  Package     : uart_defs
//  Description : Shared definitions for the 8N1 UART transmitter: frame FSM
//                state encoding, data width and a constant clog2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS = 8;

  // Ceiling log2, usable in constant expressions for counter widths.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and raises tick
//                for the single cycle spent at the terminal count. While clr
//                is high the count is held at zero so a new bit period always
//                starts from a known phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W    = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Free-running bit-period counter, held at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (count == TERMINAL)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == TERMINAL) && !clr;

endmodule
`default_nettype wire

// File: rtl/uart_tx_8n1.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_8n1
//  Description : 8N1 serial transmitter. A rising edge on transmit while idle
//                latches data and sends start bit, 8 data bits LSB first and
//                one stop bit, each CLKS_PER_BIT clocks long. Edges seen while
//                a frame is in flight are dropped. tx and busy are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_8n1
  import uart_defs::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       transmit,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int               IDX_W    = clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  // A one-clock bit period cannot be produced by the tick generator.
  if (CLKS_PER_BIT < 2) begin : g_bad_cfg
    $error("uart_tx_8n1: CLKS_PER_BIT must be at least 2");
  end

  state_t                 state;
  logic                   transmit_q;
  logic [DATA_BITS-1:0]   shift;
  logic [IDX_W-1:0]       bit_idx;
  logic                   tick;
  logic                   tx_edge;
  logic                   baud_clr;

  // The counter idles at zero so the start bit gets a full period.
  assign baud_clr = (state == IDLE);
  assign tx_edge  = transmit & ~transmit_q;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .tick  (tick)
  );

  // Edge detector: previous-cycle copy of the request level. Reset to 0 so a
  // request already high at reset release is taken as a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      transmit_q <= 1'b0;
    end else begin
      transmit_q <= transmit;
    end
  end

  // Frame FSM with registered line and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (tx_edge) begin
            shift <= data;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {1'b0, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx    <= shift[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_8n1.md
Name: uart_tx_8n1

Overview:
- Serial UART transmitter, 8 data bits, no parity, 1 stop bit (8N1).
- Sits directly downstream of the button debouncer and consumes its `transmit` strobe.
- Each rising edge of `transmit` sends one frame carrying the byte on `data` (board switches) out on the `tx` pin.
- Contains a baud-rate counter, a frame FSM, a bit counter and a shift register.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide, truncating), clocks per bit; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- transmit  input  1  request from debouncer. Level may stay high for many clk cycles; only its rising edge counts.
- data  input  8  byte to send; sampled only in the edge-accept cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst_n=0, async, immediate effect):
  - tx=1, busy=0, state=IDLE.
  - Baud counter, bit counter and shift register cleared; edge-detect register cleared to 0.
- Edge detect: `transmit_q` registers `transmit` every cycle. An edge is `transmit & ~transmit_q`.
  - If `transmit` is already high when reset is released, that counts as an edge on the first cycle out of reset.
- State IDLE:
  - tx=1, busy=0.
  - On an edge in cycle N: latch data into the shift register, clear the baud counter, go to START.
  - From cycle N+1: tx=0, busy=1.
- State START:
  - tx=0 for CLKS_PER_BIT cycles.
  - At the terminal count: bit index=0, go to DATA.
- State DATA:
  - tx=shift[0] (LSB first), held for CLKS_PER_BIT cycles per bit.
  - At each terminal count: shift right by one and increment the bit index.
  - After bit index 7 completes, go to STOP.
- State STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the terminal count: go to IDLE. busy=0 from the next cycle.
- Frame length: busy is high from N+1 through N+10*CLKS_PER_BIT inclusive.
- Registered outputs: tx and busy are both registered, so they never glitch.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at the terminal count.
  - Held at 0 in IDLE.
- Edges while busy are dropped, not queued. `data` changes while busy have no effect on the frame in flight.
- Back-to-back frames:
  - An edge whose rising cycle coincides with the STOP→IDLE transition cycle is dropped.
  - An edge seen in any IDLE cycle is accepted.
  - The minimum gap between frames is therefore one idle-high cycle after the stop bit.
- Reset mid-frame: the line returns high immediately, the frame is aborted and nothing is resumed.
- Holding `transmit` high produces exactly one frame. A new frame needs `transmit` to go low and then high again.

Decomposition:
- Shared package/header `uart_defs`:
  - State encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - DATA_BITS=8.
  - clog2 function.
- Natural sub-module: `baud_tick_gen`.
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst_n, clr.
  - Output `tick`, a one-cycle pulse at the terminal count.
- The FSM, shift register and edge detect stay in uart_tx_8n1.

Test Plan (CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10):
1. Reset released with transmit=0 → tx=1 and busy=0 for 50 cycles; no activity.
2. data=8'hA5, transmit rises at cycle N and stays high 300 cycles:
   - tx sampled mid-bit (cycle N+6+10k, k=0..9) reads 0,1,0,1,0,0,1,0,1,1.
   - busy high over N+1..N+100; exactly one frame, none further while transmit stays high.
3. data=8'h3C, edge at N; data changed to 8'hFF at N+5 → the frame still carries 3C (bits 0,0,1,1,1,1,0,0 after start).
4. Second rising edge at N+40 during a frame → ignored. busy falls at N+101 and tx stays 1 afterwards.
5. Frame started; rst_n pulled low at N+45 (mid data bit) → tx=1 and busy=0 in the same cycle, without waiting for a clock. After release, a fresh edge yields a complete, correct frame.
6. Back-to-back: edge at N, transmit low at N+50, high again at N+101 (first IDLE cycle) → second frame starts, with tx=0 at N+102.
